// File: rtl/riscv_mem_pkg.sv
// Shared types for the single-port memory scheduler: FSM states, the latched
// request record and the instruction-word select helper.
package riscv_mem_pkg;

    localparam int MEM_W   = 64;
    localparam int INSTR_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RESP
    } arb_state_t;

    // owner: 1 = data path, 0 = fetch path; wsel picks the upper fetch word
    typedef struct packed {
        logic               owner;
        logic               we;
        logic [MEM_W-1:0]   addr;
        logic               wsel;
        logic [MEM_W-1:0]   wdata;
    } arb_req_t;

    function automatic logic [INSTR_W-1:0] selectWord(input logic [MEM_W-1:0] dword,
                                                      input logic hi);
        return hi ? dword[MEM_W-1:INSTR_W] : dword[INSTR_W-1:0];
    endfunction

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one 64-bit fixed-latency memory port between instruction fetch and
// data load/store, using level-req / pulse-ack handshakes on both sides.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate any pending request
// ACCESS | address (and one-cycle store strobe) on the port, counting latency
// RESP   | read data captured, owner's ack pulses, always back to IDLE
module mem_port_arbiter
    import riscv_mem_pkg::*;
#(
    parameter int MEM_LAT  = 2,
    parameter bit FIX_PRIO = 1'b0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              i_req,
    input  logic [MEM_W-1:0]  i_addr,
    output logic              i_ack,
    output logic [INSTR_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [MEM_W-1:0]  d_addr,
    input  logic [MEM_W-1:0]  d_wdata,
    output logic              d_ack,
    output logic [MEM_W-1:0]  d_rdata,
    output logic [MEM_W-1:0]  m_raddress,
    output logic [MEM_W-1:0]  m_waddress,
    output logic [MEM_W-1:0]  m_datain,
    output logic              m_wr,
    input  logic [MEM_W-1:0]  m_dataout,
    output logic              busy,
    output logic              grant_d
);

    localparam int CNT_W = $clog2(MEM_LAT + 1);

    arb_state_t       state;
    arb_req_t         cur;
    arb_req_t         nextReq;
    logic [CNT_W-1:0] cnt;
    logic             lastD;
    logic             pickD;
    logic             anyReq;
    logic             unusedAddrBits;

    assign unusedAddrBits = ^{i_addr[1:0], d_addr[2:0]};

    // Tie-break: fixed data priority, or whoever was not served last.
    always_comb begin
        anyReq = i_req | d_req;
        pickD  = 1'b0;
        if (i_req && d_req) begin
            pickD = FIX_PRIO ? 1'b1 : !lastD;
        end else begin
            pickD = d_req;
        end
    end

    always_comb begin
        nextReq       = '0;
        nextReq.owner = pickD;
        if (pickD) begin
            nextReq.we    = d_we;
            nextReq.addr  = {d_addr[MEM_W-1:3], 3'b000};
            nextReq.wdata = d_wdata;
        end else begin
            nextReq.addr  = {i_addr[MEM_W-1:3], 3'b000};
            nextReq.wsel  = i_addr[2];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state      <= IDLE;
            cur        <= '0;
            cnt        <= '0;
            lastD      <= 1'b0;
            i_ack      <= 1'b0;
            d_ack      <= 1'b0;
            i_rdata    <= '0;
            d_rdata    <= '0;
            m_raddress <= '0;
            m_waddress <= '0;
            m_datain   <= '0;
            m_wr       <= 1'b0;
            busy       <= 1'b0;
            grant_d    <= 1'b0;
        end else begin
            i_ack <= 1'b0;
            d_ack <= 1'b0;
            m_wr  <= 1'b0;
            case (state)
                IDLE: begin
                    if (anyReq) begin
                        state      <= ACCESS;
                        cur        <= nextReq;
                        cnt        <= CNT_W'(MEM_LAT - 1);
                        lastD      <= pickD;
                        grant_d    <= pickD;
                        busy       <= 1'b1;
                        m_raddress <= nextReq.addr;
                        m_waddress <= nextReq.addr;
                        m_datain   <= nextReq.wdata;
                        m_wr       <= nextReq.owner & nextReq.we;
                    end
                end
                ACCESS: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        m_raddress <= '0;
                        m_waddress <= '0;
                        m_datain   <= '0;
                        if (cur.owner) begin
                            d_ack <= 1'b1;
                            if (!cur.we) begin
                                d_rdata <= m_dataout;
                            end
                        end else begin
                            i_ack   <= 1'b1;
                            i_rdata <= selectWord(m_dataout, cur.wsel);
                        end
                    end else begin
                        cnt        <= cnt - 1'b1;
                        m_raddress <= cur.addr;
                        m_waddress <= cur.addr;
                        m_datain   <= cur.wdata;
                    end
                end
                RESP: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // A requester must hold req until it has seen its ack.
    logic iHeld;
    logic dHeld;

    always_ff @(posedge clock) begin
        iHeld <= !reset && i_req && !i_ack;
        dHeld <= !reset && d_req && !d_ack;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            assert (!(iHeld && !i_req)) else $error("i_req dropped before i_ack");
            assert (!(dHeld && !d_req)) else $error("d_req dropped before d_ack");
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a schedule-level model checks the main instance
// every cycle; two extra instances cover fixed priority and MEM_LAT=1.
module tb_mem_port_arbiter;

    localparam int LAT = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h, want %h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // ---------------- main instance (MEM_LAT=2, round-robin) ----------------
    logic        reset, i_req, d_req, d_we;
    logic [63:0] i_addr, d_addr, d_wdata;
    logic        i_ack, d_ack, m_wr, busy, grant_d;
    logic [31:0] i_rdata;
    logic [63:0] d_rdata, m_raddress, m_waddress, m_datain, m_dataout;
    logic [63:0] mem    [256];
    logic [63:0] refMem [256];

    assign m_dataout = mem[m_raddress[10:3]];
    always @(posedge clock) if (m_wr) mem[m_waddress[10:3]] <= m_datain;

    mem_port_arbiter #(.MEM_LAT(LAT), .FIX_PRIO(1'b0)) dut (
        .clock(clock), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ack(d_ack), .d_rdata(d_rdata),
        .m_raddress(m_raddress), .m_waddress(m_waddress), .m_datain(m_datain),
        .m_wr(m_wr), .m_dataout(m_dataout), .busy(busy), .grant_d(grant_d));

    // Model: an access granted in cycle s owns the port in s+1..s+LAT,
    // acks in s+LAT+1, and the next grant can happen no earlier than s+LAT+2.
    int          mStart  = -100;
    logic        modelOn = 1'b0;
    logic        mOwnerD = 1'b0, mWe = 1'b0, mWsel = 1'b0, mLastD = 1'b0;
    logic [63:0] mAddr = '0, mWdata = '0;
    logic        eIack = 1'b0, eDack = 1'b0, eMwr = 1'b0, eBusy = 1'b0, eGrant = 1'b0;
    logic [31:0] eIrdata = '0;
    logic [63:0] eDrdata = '0, eMaddr = '0, eMdatain = '0;

    always @(negedge clock) begin
        int k;
        int kn;
        logic [63:0] word;
        if (modelOn) begin
            chk("i_ack", 64'(i_ack), 64'(eIack));
            chk("d_ack", 64'(d_ack), 64'(eDack));
            chk("i_rdata", 64'(i_rdata), 64'(eIrdata));
            chk("d_rdata", d_rdata, eDrdata);
            chk("m_raddress", m_raddress, eMaddr);
            chk("m_waddress", m_waddress, eMaddr);
            chk("m_datain", m_datain, eMdatain);
            chk("m_wr", 64'(m_wr), 64'(eMwr));
            chk("busy", 64'(busy), 64'(eBusy));
            chk("grant_d", 64'(grant_d), 64'(eGrant));
        end
        if (reset) begin
            modelOn = 1'b1;
            mStart  = -100;
            mOwnerD = 1'b0; mLastD = 1'b0; mWe = 1'b0; mWsel = 1'b0;
            eIack = 1'b0; eDack = 1'b0; eMwr = 1'b0; eBusy = 1'b0; eGrant = 1'b0;
            eIrdata = '0; eDrdata = '0; eMaddr = '0; eMdatain = '0;
        end else if (modelOn) begin
            k = cyc - mStart;
            if (!(k >= 1 && k <= LAT + 1) && (i_req || d_req)) begin
                mOwnerD = d_req && (!i_req || !mLastD);
                mLastD  = mOwnerD;
                mStart  = cyc;
                if (mOwnerD) begin
                    mAddr = d_addr & ~64'h7; mWe = d_we; mWdata = d_wdata; mWsel = 1'b0;
                end else begin
                    mAddr = i_addr & ~64'h7; mWe = 1'b0; mWdata = '0; mWsel = i_addr[2];
                end
            end
            kn       = cyc + 1 - mStart;
            eBusy    = (kn >= 1 && kn <= LAT + 1);
            eMaddr   = (kn >= 1 && kn <= LAT) ? mAddr : 64'h0;
            eMdatain = (kn >= 1 && kn <= LAT) ? mWdata : 64'h0;
            eMwr     = (kn == 1) && mOwnerD && mWe;
            if (eMwr) refMem[mAddr[10:3]] = mWdata;
            eIack    = (kn == LAT + 1) && !mOwnerD;
            eDack    = (kn == LAT + 1) && mOwnerD;
            word     = refMem[mAddr[10:3]];
            if (eIack) eIrdata = mWsel ? word[63:32] : word[31:0];
            if (eDack && !mWe) eDrdata = word;
            eGrant   = mOwnerD;
        end
        cyc++;
    end

    int          wrCount = 0;
    logic [63:0] wrAddr  = '0;
    always @(negedge clock) if (m_wr === 1'b1) begin wrCount++; wrAddr = m_waddress; end

    task automatic waitAck(input logic isData, output int lat);
        lat = 0;
        while (lat <= 20) begin
            @(negedge clock);
            if ((isData ? d_ack : i_ack) === 1'b1) break;
            @(posedge clock);
            #1;
            lat++;
        end
        step();
    endtask

    // ---------------- fixed-priority instance ----------------
    logic        r1, ireq1, dreq1, iack1, dack1, gd1, unusedMwr1, unusedBusy1, done1;
    logic [31:0] irdata1;
    logic [63:0] drdata1, mra1, mdo1, unusedMwa1, unusedMdi1;
    assign mdo1 = {~mra1[31:0], mra1[31:0]} ^ {mra1[63:32], 32'h0};

    mem_port_arbiter #(.MEM_LAT(2), .FIX_PRIO(1'b1)) dutPrio (
        .clock(clock), .reset(r1),
        .i_req(ireq1), .i_addr(64'h10), .i_ack(iack1), .i_rdata(irdata1),
        .d_req(dreq1), .d_we(1'b0), .d_addr(64'h40), .d_wdata(64'h0),
        .d_ack(dack1), .d_rdata(drdata1),
        .m_raddress(mra1), .m_waddress(unusedMwa1), .m_datain(unusedMdi1),
        .m_wr(unusedMwr1), .m_dataout(mdo1), .busy(unusedBusy1), .grant_d(gd1));

    initial begin
        r1 = 1'b1; ireq1 = 1'b0; dreq1 = 1'b0; done1 = 1'b0;
        repeat (3) step();
        r1 = 1'b0;
        step();
        ireq1 = 1'b1; dreq1 = 1'b1;
        for (int k = 0; k < 21; k++) begin
            if (k == 16) dreq1 = 1'b0;
            if (k == 20) ireq1 = 1'b0;
            @(negedge clock);
            if (k < 16) begin
                chk("prio_dack", 64'(dack1), 64'(k % 4 == 3));
                chk("prio_iack", 64'(iack1), 64'h0);
            end else begin
                chk("prio_dack_late", 64'(dack1), 64'h0);
                chk("prio_iack_late", 64'(iack1), 64'(k == 19));
            end
            if (k == 1) chk("prio_grant_d", 64'(gd1), 64'h1);
            if (k == 3) chk("prio_drdata", drdata1, 64'hFFFF_FFBF_0000_0040);
            if (k == 19) begin
                chk("prio_irdata", 64'(irdata1), 64'h10);
                chk("prio_grant_i", 64'(gd1), 64'h0);
            end
            step();
        end
        done1 = 1'b1;
    end

    // ---------------- MEM_LAT=1 instance ----------------
    logic        r2, ireq2, iack2, unusedDack2, unusedMwr2, unusedBusy2, unusedGd2, done2;
    logic [31:0] irdata2;
    logic [63:0] iaddr2, mra2, mdo2, unusedDrdata2, unusedMwa2, unusedMdi2;
    assign mdo2 = {~mra2[31:0], mra2[31:0]} ^ {mra2[63:32], 32'h0};

    mem_port_arbiter #(.MEM_LAT(1), .FIX_PRIO(1'b0)) dutLat1 (
        .clock(clock), .reset(r2),
        .i_req(ireq2), .i_addr(iaddr2), .i_ack(iack2), .i_rdata(irdata2),
        .d_req(1'b0), .d_we(1'b0), .d_addr(64'h0), .d_wdata(64'h0),
        .d_ack(unusedDack2), .d_rdata(unusedDrdata2),
        .m_raddress(mra2), .m_waddress(unusedMwa2), .m_datain(unusedMdi2),
        .m_wr(unusedMwr2), .m_dataout(mdo2), .busy(unusedBusy2), .grant_d(unusedGd2));

    initial begin
        logic [31:0] wantWord [2];
        logic [63:0] reqAddr  [2];
        reqAddr[0] = 64'h10; wantWord[0] = 32'h0000_0010;
        reqAddr[1] = 64'h14; wantWord[1] = 32'hFFFF_FFEF;
        r2 = 1'b1; ireq2 = 1'b0; iaddr2 = '0; done2 = 1'b0;
        repeat (3) step();
        r2 = 1'b0;
        step();
        for (int t = 0; t < 2; t++) begin
            iaddr2 = reqAddr[t];
            ireq2  = 1'b1;
            for (int k = 0; k < 4; k++) begin
                if (k == 3) ireq2 = 1'b0;
                @(negedge clock);
                chk("lat1_iack", 64'(iack2), 64'(k == 2));
                chk("lat1_raddr", mra2, (k == 1) ? 64'h10 : 64'h0);
                if (k == 2) chk("lat1_irdata", 64'(irdata2), 64'(wantWord[t]));
                step();
            end
        end
        done2 = 1'b1;
    end

    // ---------------- main directed sequence ----------------
    initial begin
        int lat;
        int ackKind [$];
        int ackCyc  [$];
        int wantKind [4];
        int wantCyc  [4];
        wantKind = '{1, 0, 1, 0};
        wantCyc  = '{3, 7, 11, 15};
        for (int i = 0; i < 256; i++) begin
            mem[i]    = {32'h5A00_0000 + 32'(i), 32'hA500_0000 + 32'(i)};
            refMem[i] = mem[i];
        end
        mem[8'h20]    = 64'hAAAA_BBBB_0000_0013;
        refMem[8'h20] = 64'hAAAA_BBBB_0000_0013;
        reset = 1'b1; i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
        i_addr = '0; d_addr = '0; d_wdata = '0;
        repeat (3) step();
        reset = 1'b0;
        step();
        @(negedge clock);
        chk("reset_busy", 64'(busy), 64'h0);
        chk("reset_grant", 64'(grant_d), 64'h0);
        step();

        // Fetch of the upper word at 0x100
        i_req = 1'b1; i_addr = 64'h104;
        waitAck(1'b0, lat);
        i_req = 1'b0;
        chk("fetch_latency", 64'(lat), 64'd3);
        chk("fetch_rdata", 64'(i_rdata), 64'hAAAA_BBBB);

        // Store, then load back
        wrCount = 0;
        d_req = 1'b1; d_we = 1'b1; d_addr = 64'h20D; d_wdata = 64'h1122_3344_5566_7788;
        waitAck(1'b1, lat);
        d_req = 1'b0; d_we = 1'b0;
        chk("store_latency", 64'(lat), 64'd3);
        chk("store_wr_pulses", 64'(wrCount), 64'd1);
        chk("store_waddress", wrAddr, 64'h208);
        chk("store_keeps_drdata", d_rdata, 64'h0);
        step();
        d_req = 1'b1; d_addr = 64'h208;
        waitAck(1'b1, lat);
        d_req = 1'b0;
        chk("load_latency", 64'(lat), 64'd3);
        chk("load_rdata", d_rdata, 64'h1122_3344_5566_7788);

        // Reset in the second ACCESS cycle of a load
        d_req = 1'b1; d_addr = 64'h100;
        step();
        step();
        reset = 1'b1; d_req = 1'b0;
        step();
        reset = 1'b0;
        @(negedge clock);
        chk("rst_mid_busy", 64'(busy), 64'h0);
        chk("rst_mid_dack", 64'(d_ack), 64'h0);
        chk("rst_mid_irdata", 64'(i_rdata), 64'h0);
        chk("rst_mid_drdata", d_rdata, 64'h0);
        chk("rst_mid_raddr", m_raddress, 64'h0);
        step();
        step();

        // Both requesting: data first after reset, then alternating
        i_addr = 64'h100; d_addr = 64'h208; d_we = 1'b0;
        i_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 16; k++) begin
            if (k == 12) d_req = 1'b0;
            @(negedge clock);
            if (i_ack === 1'b1) begin ackKind.push_back(0); ackCyc.push_back(k); end
            if (d_ack === 1'b1) begin ackKind.push_back(1); ackCyc.push_back(k); end
            step();
        end
        i_req = 1'b0;
        chk("alt_ack_count", 64'(ackKind.size()), 64'd4);
        for (int j = 0; j < ackKind.size() && j < 4; j++) begin
            chk("alt_owner", 64'(ackKind[j]), 64'(wantKind[j]));
            chk("alt_cycle", 64'(ackCyc[j]), 64'(wantCyc[j]));
        end
        chk("alt_irdata", 64'(i_rdata), 64'h13);
        chk("alt_drdata", d_rdata, 64'h1122_3344_5566_7788);

        // Data request arriving during a fetch access waits for the next IDLE
        i_addr = 64'h10C; d_addr = 64'h100; i_req = 1'b1;
        for (int k = 0; k < 9; k++) begin
            if (k == 1) d_req = 1'b1;
            if (k == 4) i_req = 1'b0;
            if (k == 8) d_req = 1'b0;
            @(negedge clock);
            if (k == 3) chk("late_iack", 64'(i_ack), 64'h1);
            if (k == 4) chk("late_idle_busy", 64'(busy), 64'h0);
            if (k == 5) chk("late_grant_d", 64'(grant_d), 64'h1);
            if (k == 6) chk("late_dack_early", 64'(d_ack), 64'h0);
            if (k == 7) chk("late_dack", 64'(d_ack), 64'h1);
            step();
        end
        chk("late_irdata", 64'(i_rdata), 64'h5A00_0021);
        chk("late_drdata", d_rdata, 64'hAAAA_BBBB_0000_0013);

        repeat (3) step();
        for (int t = 0; t < 100 && !(done1 && done2); t++) step();
        chk("side_instances_done", 64'(done1 && done2), 64'h1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Multicycle scheduler that shares one 64-bit memory port between the instruction-fetch path (PC/IR side) and the data load/store path (ALUOut/regB/MDR side). It lets the processor replace its separate instruction and data memories with a single memory.
- Each requester uses a level-req / pulse-ack handshake.
- The arbiter latches the winning request and sequences the fixed-latency memory access.
- It returns read data aligned for the requester.

Parameters:
- MEM_LAT, 2: memory read latency in cycles from address presented to m_dataout valid; legal values are 1 to 8.
- FIX_PRIO, 0: 0 selects alternating (round-robin) tie-break; 1 selects data always beating fetch.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- i_req  in  1  fetch request; level, held until i_ack
- i_addr  in  64  fetch byte address; bits [1:0] ignored
- i_ack  out  1  one-cycle pulse; i_rdata valid in the same cycle
- i_rdata  out  32  fetched instruction word
- d_req  in  1  data request; level, held until d_ack
- d_we  in  1  1 = store, 0 = load; stable while d_req is high
- d_addr  in  64  data byte address; bits [2:0] forced to 0
- d_wdata  in  64  store data
- d_ack  out  1  one-cycle pulse
- d_rdata  out  64  load data; valid with d_ack for loads
- m_raddress  out  64  memory read address
- m_waddress  out  64  memory write address; same value as m_raddress
- m_datain  out  64  memory write data
- m_wr  out  1  memory write strobe
- m_dataout  in  64  memory read data
- busy  out  1  high when state is not IDLE
- grant_d  out  1  current/last owner: 1 = data, 0 = fetch

Behaviour:
- One clock domain, clock. Reset is synchronous and active-high; all state changes on the rising edge of clock.
- Reset values: state=IDLE; i_ack=0, d_ack=0, m_wr=0, busy=0, grant_d=0; i_rdata=0, d_rdata=0; m_* address/data=0; last_d=0; cnt=0.
- States: IDLE, ACCESS, RESP.
- IDLE:
  - No request: remain in IDLE.
  - Any request pending: at the edge, latch owner, address, we and wdata; load cnt=MEM_LAT-1; go to ACCESS.
  - Fetch address is latched as {i_addr[63:3],3'b000} plus word-select bit i_addr[2].
  - Data address is latched as {d_addr[63:3],3'b000}.
- Arbitration, both requests high in IDLE:
  - FIX_PRIO=1: data wins.
  - FIX_PRIO=0: the requester not served last wins. last_d=0 after reset, so data wins the first tie.
  - Single request: that requester wins.
  - last_d is updated on every grant.
- ACCESS:
  - m_raddress and m_waddress are driven from the latched address for all ACCESS cycles.
  - m_wr=1 only in the first ACCESS cycle, and only for a data store.
  - m_datain carries the latched wdata throughout ACCESS.
  - cnt decrements each cycle. When cnt==0, the edge captures m_dataout and moves to RESP.
- RESP (one cycle):
  - The owner's ack is 1.
  - Fetch: i_rdata = captured[63:32] if the word-select bit is 1, otherwise captured[31:0].
  - Data load: d_rdata = captured value.
  - Data store: d_rdata holds its previous value.
  - RESP always goes to IDLE.
- Latency: a request arriving in IDLE at cycle T gets its ack in cycle T+MEM_LAT+1. With MEM_LAT=2, ack arrives 3 cycles after req. Back-to-back accesses occupy MEM_LAT+2 cycles each, because of the mandatory IDLE cycle.
- Handshake rules:
  - The requester samples ack at the clock edge.
  - req seen high in the IDLE cycle after ack is a new request.
  - Dropping req before ack is a protocol violation: flag it with a simulation assertion. The access still completes and ack still pulses.
  - i_rdata and d_rdata hold their values until the next ack to the same port.
- A request that arrives during ACCESS or RESP waits; it is arbitrated in the next IDLE cycle.
- Reset mid-access: the reset edge forces all reset values. No ack is issued and no further m_wr is driven. A store whose m_wr already fired is not undone.
- Outputs are registered from state registers; no combinational path from req to m_* outputs.
- grant_d updates at grant and holds through IDLE.

Decomposition:
- Package riscv_mem_pkg:
  - typedef enum logic [1:0] arb_state_t {IDLE, ACCESS, RESP}
  - localparam MEM_W=64, INSTR_W=32
  - typedef struct of the latched request {owner, we, addr, wsel, wdata}
- Counter width: $clog2(MEM_LAT+1).
- No sub-module required. The tie-break picker stays as an always_comb block inside the module.

Test Plan:
- Reset, then i_req=1 with i_addr=0x104, memory word at 0x100 = 0xAAAA_BBBB_0000_0013: i_ack pulses in cycle 3 with i_rdata=0xAAAA_BBBB.
- d_req=1, d_we=1, d_addr=0x20D, d_wdata=0x1122334455667788: m_wr is high for exactly one cycle with m_waddress=0x208. A following load from 0x208 returns d_rdata=0x1122334455667788.
- i_req and d_req both high continuously with FIX_PRIO=0: grants alternate D,I,D,I, each ack 4 cycles apart (MEM_LAT=2). With FIX_PRIO=1, data receives all grants while d_req stays high.
- d_req raised during an active fetch ACCESS: the fetch ack comes first, then one IDLE cycle, then the data grant; d_ack follows 3 cycles after that IDLE.
- reset asserted in the second ACCESS cycle of a load: no d_ack; busy=0 and all outputs at reset values on the next cycle.
- MEM_LAT=1 build, single fetch: ack 2 cycles after req; m_raddress held for exactly 1 cycle.
